// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared states, opcodes and select encodings for the LC-3 controller
package lc3_pkg;

    typedef enum logic [5:0] {
        S_IDLE,
        S_FET0,
        S_FET1,
        S_FET2,
        S_DECODE,
        S_ALU,
        S_BR,
        S_JMP,
        S_JSR0,
        S_JSR1,
        S_JSRR1,
        S_LEA,
        S_LD0,
        S_LDR0,
        S_LD1,
        S_LD2,
        S_LDI0,
        S_LDI1,
        S_LDI2,
        S_ST0,
        S_STR0,
        S_ST1,
        S_ST2,
        S_STI0,
        S_STI1,
        S_STI2,
        S_TRAP0,
        S_TRAP1,
        S_TRAP2,
        S_TRAP3,
        S_ILLEGAL,
        S_HALT,
        S_FAULT
    } state_e;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_NOT   = 2'b10;
    localparam logic [1:0] ALU_PASSA = 2'b11;

    localparam logic [1:0] EAB2_ZERO  = 2'b00;
    localparam logic [1:0] EAB2_OFF6  = 2'b01;
    localparam logic [1:0] EAB2_OFF9  = 2'b10;
    localparam logic [1:0] EAB2_OFF11 = 2'b11;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_EAB = 2'b01;
    localparam logic [1:0] PC_BUS = 2'b10;

    // States that hold a memory access open until mem_rdy
    function automatic logic is_wait(input state_e s);
        return (s == S_FET1) || (s == S_LD1) || (s == S_LDI1) ||
               (s == S_TRAP2) || (s == S_ST2) || (s == S_STI1);
    endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// rtl/lc3_mem_wait.sv - memory wait-state counter with timeout detection
module lc3_mem_wait #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic rdy,
    output logic done,
    output logic timeout
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count waiting cycles; any cycle outside a wait state or completing one clears the count
    always_comb begin
        cnt_d = '0;
        if (start && !rdy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The waiting cycle that would bring the count to MEM_TIMEOUT without rdy is the fault point
    assign done    = start && rdy;
    assign timeout = start && !rdy && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/lc3_ctrl.sv
// rtl/lc3_ctrl.sv - LC-3 control FSM driving datapath enables, loads, selects and register addresses
module lc3_ctrl
    import lc3_pkg::*;
#(
    parameter int          MEM_TIMEOUT = 16,
    parameter logic [7:0]  HALT_VECT   = 8'h25,
    localparam int         CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic        mem_rdy,
    output logic        ena_pc,
    output logic        ena_mdr,
    output logic        ena_alu,
    output logic        ena_marm,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic        ld_cc,
    output logic        reg_we,
    output logic        mem_en,
    output logic        mem_we,
    output logic        sel_mdr,
    output logic        sel_marm,
    output logic        sel_eab1,
    output logic [1:0]  sel_eab2,
    output logic [1:0]  sel_pc,
    output logic [1:0]  alu_ctrl,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic        halted,
    output logic        fault,
    output logic        illegal
);

    state_e state_q;
    logic   mw_done;
    logic   mw_timeout;
    logic   ir_unused;

    // Offset/immediate bits [5:3] are consumed by the datapath, not the controller
    assign ir_unused = ^ir[5:3];

    lc3_mem_wait #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait (
        .clk     (clk),
        .rst     (rst),
        .start   (is_wait(state_q)),
        .rdy     (mem_rdy),
        .done    (mw_done),
        .timeout (mw_timeout)
    );

    // State sequencing: fetch, decode dispatch, execute, with HALT and FAULT absorbing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_q <= S_FET0;
                S_FET0:    state_q <= S_FET1;
                S_FET1:    state_q <= mw_timeout ? S_FAULT : (mw_done ? S_FET2  : S_FET1);
                S_FET2:    state_q <= S_DECODE;
                S_DECODE: begin
                    case (ir[15:12])
                        OP_ADD, OP_AND, OP_NOT: state_q <= S_ALU;
                        OP_BR:   state_q <= S_BR;
                        OP_JMP:  state_q <= S_JMP;
                        OP_JSR:  state_q <= S_JSR0;
                        OP_LEA:  state_q <= S_LEA;
                        OP_LD:   state_q <= S_LD0;
                        OP_LDR:  state_q <= S_LDR0;
                        OP_LDI:  state_q <= S_LDI0;
                        OP_ST:   state_q <= S_ST0;
                        OP_STR:  state_q <= S_STR0;
                        OP_STI:  state_q <= S_STI0;
                        OP_TRAP: state_q <= (ir[7:0] == HALT_VECT) ? S_HALT : S_TRAP0;
                        OP_RTI, OP_RES: state_q <= S_ILLEGAL;
                        default: state_q <= S_ILLEGAL;
                    endcase
                end
                S_JSR0:    state_q <= ir[11] ? S_JSR1 : S_JSRR1;
                S_LD0:     state_q <= S_LD1;
                S_LDR0:    state_q <= S_LD1;
                S_LD1:     state_q <= mw_timeout ? S_FAULT : (mw_done ? S_LD2   : S_LD1);
                S_LDI0:    state_q <= S_LDI1;
                S_LDI1:    state_q <= mw_timeout ? S_FAULT : (mw_done ? S_LDI2  : S_LDI1);
                S_LDI2:    state_q <= S_LD1;
                S_ST0:     state_q <= S_ST1;
                S_STR0:    state_q <= S_ST1;
                S_ST1:     state_q <= S_ST2;
                S_ST2:     state_q <= mw_timeout ? S_FAULT : (mw_done ? S_FET0  : S_ST2);
                S_STI0:    state_q <= S_STI1;
                S_STI1:    state_q <= mw_timeout ? S_FAULT : (mw_done ? S_STI2  : S_STI1);
                S_STI2:    state_q <= S_ST1;
                S_TRAP0:   state_q <= S_TRAP1;
                S_TRAP1:   state_q <= S_TRAP2;
                S_TRAP2:   state_q <= mw_timeout ? S_FAULT : (mw_done ? S_TRAP3 : S_TRAP2);
                S_HALT:    state_q <= S_HALT;
                S_FAULT:   state_q <= S_FAULT;
                default:   state_q <= S_FET0;
            endcase
        end
    end

    // Output decode from the current state and instruction; only BR and read waits also look at inputs
    always_comb begin
        ena_pc   = 1'b0;
        ena_mdr  = 1'b0;
        ena_alu  = 1'b0;
        ena_marm = 1'b0;
        ld_mar   = 1'b0;
        ld_mdr   = 1'b0;
        ld_ir    = 1'b0;
        ld_pc    = 1'b0;
        ld_cc    = 1'b0;
        reg_we   = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        sel_mdr  = 1'b0;
        sel_marm = 1'b0;
        sel_eab1 = 1'b0;
        sel_eab2 = EAB2_ZERO;
        sel_pc   = PC_INC;
        alu_ctrl = ALU_ADD;
        dr       = 3'd0;
        sr1      = 3'd0;
        sr2      = 3'd0;
        halted   = 1'b0;
        fault    = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FET0: begin
                ena_pc = 1'b1;
                ld_mar = 1'b1;
                ld_pc  = 1'b1;
            end
            S_FET1, S_LD1, S_LDI1, S_TRAP2, S_STI1: begin
                mem_en  = 1'b1;
                sel_mdr = 1'b1;
                ld_mdr  = mem_rdy;
            end
            S_FET2: begin
                ena_mdr = 1'b1;
                ld_ir   = 1'b1;
            end
            S_ALU: begin
                dr      = ir[11:9];
                sr1     = ir[8:6];
                sr2     = ir[2:0];
                ena_alu = 1'b1;
                reg_we  = 1'b1;
                ld_cc   = 1'b1;
                case (ir[15:12])
                    OP_AND:  alu_ctrl = ALU_AND;
                    OP_NOT:  alu_ctrl = ALU_NOT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_BR: begin
                sel_pc   = PC_EAB;
                sel_eab2 = EAB2_OFF9;
                ld_pc    = (n & ir[11]) | (z & ir[10]) | (p & ir[9]);
            end
            S_JMP, S_JSRR1: begin
                sel_eab1 = 1'b1;
                sr1      = ir[8:6];
                sel_pc   = PC_EAB;
                ld_pc    = 1'b1;
            end
            S_JSR0, S_TRAP0: begin
                dr     = 3'd7;
                ena_pc = 1'b1;
                reg_we = 1'b1;
            end
            S_JSR1: begin
                sel_eab2 = EAB2_OFF11;
                sel_pc   = PC_EAB;
                ld_pc    = 1'b1;
            end
            S_LEA: begin
                sel_eab2 = EAB2_OFF9;
                ena_marm = 1'b1;
                dr       = ir[11:9];
                reg_we   = 1'b1;
                ld_cc    = 1'b1;
            end
            S_LD0, S_LDI0, S_ST0, S_STI0: begin
                sel_eab2 = EAB2_OFF9;
                ena_marm = 1'b1;
                ld_mar   = 1'b1;
            end
            S_LDR0, S_STR0: begin
                sel_eab1 = 1'b1;
                sel_eab2 = EAB2_OFF6;
                sr1      = ir[8:6];
                ena_marm = 1'b1;
                ld_mar   = 1'b1;
            end
            S_LD2: begin
                ena_mdr = 1'b1;
                reg_we  = 1'b1;
                ld_cc   = 1'b1;
                dr      = ir[11:9];
            end
            S_LDI2, S_STI2: begin
                ena_mdr = 1'b1;
                ld_mar  = 1'b1;
            end
            S_ST1: begin
                sr1      = ir[11:9];
                alu_ctrl = ALU_PASSA;
                ena_alu  = 1'b1;
                ld_mdr   = 1'b1;
            end
            S_ST2: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            S_TRAP1: begin
                sel_marm = 1'b1;
                ena_marm = 1'b1;
                ld_mar   = 1'b1;
            end
            S_TRAP3: begin
                ena_mdr = 1'b1;
                sel_pc  = PC_BUS;
                ld_pc   = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            S_HALT:    halted  = 1'b1;
            S_FAULT:   fault   = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lc3_ctrl.sv
// tb/tb_lc3_ctrl.sv - directed self-checking bench for lc3_ctrl
module tb_lc3_ctrl;

    typedef struct packed {
        logic       ena_pc;
        logic       ena_mdr;
        logic       ena_alu;
        logic       ena_marm;
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_pc;
        logic       ld_cc;
        logic       reg_we;
        logic       mem_en;
        logic       mem_we;
        logic       sel_mdr;
        logic       sel_marm;
        logic       sel_eab1;
        logic [1:0] sel_eab2;
        logic [1:0] sel_pc;
        logic [1:0] alu_ctrl;
        logic [2:0] dr;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic       halted;
        logic       fault;
        logic       illegal;
    } outs_t;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        n, z, p;
    logic        mem_rdy;
    logic        ena_pc, ena_mdr, ena_alu, ena_marm;
    logic        ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc, reg_we;
    logic        mem_en, mem_we, sel_mdr, sel_marm, sel_eab1;
    logic [1:0]  sel_eab2, sel_pc, alu_ctrl;
    logic [2:0]  dr, sr1, sr2;
    logic        halted, fault, illegal;

    outs_t o;
    outs_t e;
    int    total  = 0;
    int    passed = 0;
    int    failed = 0;

    assign o = {ena_pc, ena_mdr, ena_alu, ena_marm, ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc,
                reg_we, mem_en, mem_we, sel_mdr, sel_marm, sel_eab1, sel_eab2, sel_pc,
                alu_ctrl, dr, sr1, sr2, halted, fault, illegal};

    lc3_ctrl #(
        .MEM_TIMEOUT (4),
        .HALT_VECT   (8'h25)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ir       (ir),
        .n        (n),
        .z        (z),
        .p        (p),
        .mem_rdy  (mem_rdy),
        .ena_pc   (ena_pc),
        .ena_mdr  (ena_mdr),
        .ena_alu  (ena_alu),
        .ena_marm (ena_marm),
        .ld_mar   (ld_mar),
        .ld_mdr   (ld_mdr),
        .ld_ir    (ld_ir),
        .ld_pc    (ld_pc),
        .ld_cc    (ld_cc),
        .reg_we   (reg_we),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .sel_mdr  (sel_mdr),
        .sel_marm (sel_marm),
        .sel_eab1 (sel_eab1),
        .sel_eab2 (sel_eab2),
        .sel_pc   (sel_pc),
        .alu_ctrl (alu_ctrl),
        .dr       (dr),
        .sr1      (sr1),
        .sr2      (sr2),
        .halted   (halted),
        .fault    (fault),
        .illegal  (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic outs_t e_fet0();
        outs_t v = '0;
        v.ena_pc = 1'b1;
        v.ld_mar = 1'b1;
        v.ld_pc  = 1'b1;
        return v;
    endfunction

    function automatic outs_t e_wait(input logic r);
        outs_t v = '0;
        v.mem_en  = 1'b1;
        v.sel_mdr = 1'b1;
        v.ld_mdr  = r;
        return v;
    endfunction

    function automatic outs_t e_fet2();
        outs_t v = '0;
        v.ena_mdr = 1'b1;
        v.ld_ir   = 1'b1;
        return v;
    endfunction

    function automatic outs_t e_pcoff9();
        outs_t v = '0;
        v.sel_eab2 = 2'b10;
        v.ena_marm = 1'b1;
        v.ld_mar   = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input outs_t obs, input outs_t exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered with the DUT in FET0; leaves it in DECODE with ir loaded
    task automatic fetch(input logic [15:0] v);
        ir      = v;
        mem_rdy = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; mem_rdy = 1'b1; ir = 16'h1042; n = 1'b0; z = 1'b0; p = 1'b0;
        tick(); #1 chk("reset_idle", o, '0);
        tick(); #1 chk("reset_idle2", o, '0);
        rst = 1'b0;

        // ADD R0,R1,R2 through the full fetch
        tick(); #1 chk("add_fet0", o, e_fet0());
        tick(); #1 chk("add_fet1", o, e_wait(1'b1));
        tick(); #1 chk("add_fet2", o, e_fet2());
        tick(); #1 chk("add_decode", o, '0);
        tick();
        e = '0; e.ena_alu = 1'b1; e.reg_we = 1'b1; e.ld_cc = 1'b1;
        e.dr = 3'd0; e.sr1 = 3'd1; e.sr2 = 3'd2; e.alu_ctrl = 2'b00;
        #1 chk("add_exec", o, e);
        tick(); #1 chk("add_next_fet0", o, e_fet0());

        // LD R1 with mem_rdy arriving on the 4th waiting cycle
        fetch(16'h2205);
        tick(); #1 chk("ld_ld0", o, e_pcoff9());
        mem_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(); #1 chk($sformatf("ld_wait%0d", i), o, e_wait(1'b0));
        end
        tick(); mem_rdy = 1'b1; #1 chk("ld_wait4_rdy", o, e_wait(1'b1));
        tick();
        e = '0; e.ena_mdr = 1'b1; e.reg_we = 1'b1; e.ld_cc = 1'b1; e.dr = 3'd1;
        #1 chk("ld_ld2", o, e);
        tick(); #1 chk("ld_next_fet0", o, e_fet0());

        // BRnp: taken on n or p, not on z
        fetch(16'h0A03);
        tick();
        n = 1'b1; z = 1'b0; p = 1'b0;
        e = '0; e.sel_pc = 2'b01; e.sel_eab2 = 2'b10; e.ld_pc = 1'b1;
        #1 chk("br_n", o, e);
        n = 1'b0; z = 1'b1; e.ld_pc = 1'b0;
        #1 chk("br_z", o, e);
        z = 1'b0; p = 1'b1; e.ld_pc = 1'b1;
        #1 chk("br_p", o, e);
        p = 1'b0;
        tick(); #1 chk("br_next_fet0", o, e_fet0());

        // TRAP x25 halts and stays halted
        fetch(16'hF025);
        tick();
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1 chk("halt_hold", o, e);
            tick();
        end
        rst = 1'b1;
        tick(); #1 chk("halt_rst_idle", o, '0);
        rst = 1'b0;
        tick(); #1 chk("halt_rst_fet0", o, e_fet0());

        // TRAP x23 vectors through the table
        fetch(16'hF023);
        tick();
        e = '0; e.dr = 3'd7; e.ena_pc = 1'b1; e.reg_we = 1'b1;
        #1 chk("trap0", o, e);
        tick();
        e = '0; e.sel_marm = 1'b1; e.ena_marm = 1'b1; e.ld_mar = 1'b1;
        #1 chk("trap1", o, e);
        tick(); #1 chk("trap2", o, e_wait(1'b1));
        tick();
        e = '0; e.ena_mdr = 1'b1; e.sel_pc = 2'b10; e.ld_pc = 1'b1;
        #1 chk("trap3", o, e);
        tick(); #1 chk("trap_next_fet0", o, e_fet0());

        // Fetch timeout: four waiting cycles without mem_rdy
        mem_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(); #1 chk($sformatf("to_wait%0d", i), o, e_wait(1'b0));
        end
        e = '0; e.fault = 1'b1;
        tick(); #1 chk("to_fault", o, e);
        tick(); #1 chk("to_fault_hold", o, e);
        rst = 1'b1;
        tick(); #1 chk("to_rst_idle", o, '0);
        rst = 1'b0;
        tick(); #1 chk("to_rst_fet0", o, e_fet0());

        // mem_rdy exactly on the 4th waiting cycle completes the fetch (STI follows)
        ir = 16'hB401;
        for (int i = 1; i <= 3; i++) begin
            tick(); #1 chk($sformatf("edge_wait%0d", i), o, e_wait(1'b0));
        end
        tick(); mem_rdy = 1'b1; #1 chk("edge_wait4_rdy", o, e_wait(1'b1));
        tick(); #1 chk("edge_fet2", o, e_fet2());
        tick(); #1 chk("sti_decode", o, '0);
        tick(); #1 chk("sti0", o, e_pcoff9());
        mem_rdy = 1'b0;
        tick(); #1 chk("sti1_wait", o, e_wait(1'b0));
        rst = 1'b1;
        tick(); #1 chk("sti_rst_idle", o, '0);
        rst = 1'b0; ir = 16'h8000; mem_rdy = 1'b1;

        // RTI is illegal for exactly one cycle
        tick(); #1 chk("ill_fet0", o, e_fet0());
        tick();
        tick();
        tick(); #1 chk("ill_decode", o, '0);
        e = '0; e.illegal = 1'b1;
        tick(); #1 chk("ill_pulse", o, e);
        tick(); #1 chk("ill_next_fet0", o, e_fet0());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
